dec_arat_recov_module: RTL and testbench

Parametrised architectural register alias table (ARAT) for the decode/rename stage. It is updated by up to RET_WIDTH retiring instructions per cycle. For each retiring slot it returns the previously committed physical register, so that register can be freed. Unlike a flat 32-entry table with a fixed 4-wide port set, it resolves same-destination collisions inside a retire bundle, resets to an identity mapping, and streams the committed map to the speculative RAT and free list over a backpressured multi-beat recovery channel after a flush.

---
 rtl/dec_arat_recov_module.sv | 156 +++++++++++++++
 tb/tb_dec_arat_recov_module.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_arat_recov_module.sv
// Architectural register alias table: retire-time commit with youngest-wins collision
// handling, freed-register return, and a backpressured multi-beat recovery stream.
module dec_arat_recov_module #(
  parameter int ARF_NUM        = 32,
  parameter int ARF_CODE_WIDTH = 5,
  parameter int PRF_CODE_WIDTH = 7,
  parameter int RET_WIDTH      = 4,
  parameter int RECOV_LANES    = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [RET_WIDTH-1:0]                  i_arat_wren,
  input  logic [RET_WIDTH*ARF_CODE_WIDTH-1:0]   i_arat_wr_dst_code,
  input  logic [RET_WIDTH*PRF_CODE_WIDTH-1:0]   i_arat_wr_prf_code,
  output logic [RET_WIDTH-1:0]                  o_arat_ret_vld,
  output logic [RET_WIDTH*PRF_CODE_WIDTH-1:0]   o_arat_ret_prf_code,
  input  logic                                  i_arat_recov_req,
  output logic                                  o_arat_recov_busy,
  output logic                                  o_arat_recov_vld,
  input  logic                                  i_arat_recov_rdy,
  output logic [ARF_CODE_WIDTH-1:0]             o_arat_recov_idx,
  output logic [RECOV_LANES*PRF_CODE_WIDTH-1:0] o_arat_recov_prf_code,
  output logic                                  o_arat_recov_last
);

  localparam int BEATS  = ARF_NUM / RECOV_LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                    state_q;
  logic [BEAT_W-1:0]         beat_q;
  logic                      last_beat;

  logic [PRF_CODE_WIDTH-1:0] arat_q   [1:ARF_NUM-1];
  logic [PRF_CODE_WIDTH-1:0] arat_d   [1:ARF_NUM-1];
  logic [PRF_CODE_WIDTH-1:0] table_rd [ARF_NUM];

  logic [RET_WIDTH-1:0]      eff;
  logic [ARF_CODE_WIDTH-1:0] dst     [RET_WIDTH];
  logic [PRF_CODE_WIDTH-1:0] prf     [RET_WIDTH];
  logic [PRF_CODE_WIDTH-1:0] ret_val [RET_WIDTH];

  // Retirement is frozen while streaming so the recovery image stays coherent.
  always_comb begin
    for (int k = 0; k < RET_WIDTH; k++) begin
      dst[k] = i_arat_wr_dst_code[k*ARF_CODE_WIDTH +: ARF_CODE_WIDTH];
      prf[k] = i_arat_wr_prf_code[k*PRF_CODE_WIDTH +: PRF_CODE_WIDTH];
      eff[k] = (state_q == IDLE) && i_arat_wren[k] && (dst[k] != '0);
    end
  end

  always_comb begin
    table_rd[0] = '0;
    for (int i = 1; i < ARF_NUM; i++) begin
      table_rd[i] = arat_q[i];
    end
  end

  // An older slot in the same bundle writing the same destination supplies the freed register.
  always_comb begin
    for (int k = 0; k < RET_WIDTH; k++) begin
      ret_val[k] = table_rd[dst[k]];
      for (int j = 0; j < k; j++) begin
        if (eff[j] && (dst[j] == dst[k])) begin
          ret_val[k] = prf[j];
        end
      end
    end
  end

  always_comb begin
    o_arat_ret_prf_code = '0;
    for (int k = 0; k < RET_WIDTH; k++) begin
      if (eff[k]) begin
        o_arat_ret_prf_code[k*PRF_CODE_WIDTH +: PRF_CODE_WIDTH] = ret_val[k];
      end
    end
  end

  assign o_arat_ret_vld = eff;

  // Ascending slot order makes the youngest effective writer win.
  always_comb begin
    for (int i = 1; i < ARF_NUM; i++) begin
      arat_d[i] = arat_q[i];
      for (int k = 0; k < RET_WIDTH; k++) begin
        if (eff[k] && (dst[k] == ARF_CODE_WIDTH'(i))) begin
          arat_d[i] = prf[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 1; i < ARF_NUM; i++) begin
      if (rst) begin
        arat_q[i] <= PRF_CODE_WIDTH'(i);
      end else begin
        arat_q[i] <= arat_d[i];
      end
    end
  end

  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  // Recovery channel: a beat transfers when vld && rdy; with rdy low every
  // recovery output holds its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_arat_recov_req) begin
            state_q <= STREAM;
            beat_q  <= '0;
          end
        end
        STREAM: begin
          if (i_arat_recov_rdy) begin
            if (last_beat) begin
              state_q <= IDLE;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          beat_q  <= '0;
        end
      endcase
    end
  end

  assign o_arat_recov_busy = (state_q == STREAM);
  assign o_arat_recov_vld  = (state_q == STREAM);
  assign o_arat_recov_last = (state_q == STREAM) && last_beat;
  assign o_arat_recov_idx  = ARF_CODE_WIDTH'(int'(beat_q) * RECOV_LANES);

  always_comb begin
    o_arat_recov_prf_code = '0;
    if (state_q == STREAM) begin
      for (int j = 0; j < RECOV_LANES; j++) begin
        o_arat_recov_prf_code[j*PRF_CODE_WIDTH +: PRF_CODE_WIDTH] =
          table_rd[int'(o_arat_recov_idx) + j];
      end
    end
  end

endmodule

// File: tb/tb_dec_arat_recov_module.sv
// Directed bench for the ARAT: retire return/commit, bundle collisions and recovery streaming.
module tb_dec_arat_recov_module;

  localparam int A     = 5;
  localparam int P     = 7;
  localparam int R     = 4;
  localparam int L     = 8;
  localparam int N     = 32;
  localparam int BEATS = N / L;

  logic           clk = 1'b0;
  logic           rst;
  logic [R-1:0]   wren;
  logic [R*A-1:0] wr_dst;
  logic [R*P-1:0] wr_prf;
  logic [R-1:0]   ret_vld;
  logic [R*P-1:0] ret_prf;
  logic           req;
  logic           busy;
  logic           vld;
  logic           rdy;
  logic [A-1:0]   idx;
  logic [L*P-1:0] lanes;
  logic           last;

  int n_checks = 0;
  int n_fail   = 0;
  logic [P-1:0] exp_tbl [N];

  always #5 clk = ~clk;

  dec_arat_recov_module #(
    .ARF_NUM(N), .ARF_CODE_WIDTH(A), .PRF_CODE_WIDTH(P), .RET_WIDTH(R), .RECOV_LANES(L)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_arat_wren           (wren),
    .i_arat_wr_dst_code    (wr_dst),
    .i_arat_wr_prf_code    (wr_prf),
    .o_arat_ret_vld        (ret_vld),
    .o_arat_ret_prf_code   (ret_prf),
    .i_arat_recov_req      (req),
    .o_arat_recov_busy     (busy),
    .o_arat_recov_vld      (vld),
    .i_arat_recov_rdy      (rdy),
    .o_arat_recov_idx      (idx),
    .o_arat_recov_prf_code (lanes),
    .o_arat_recov_last     (last)
  );

  task automatic clear_slots();
    wren   = '0;
    wr_dst = '0;
    wr_prf = '0;
  endtask

  task automatic set_slot(input int k, input logic [A-1:0] d, input logic [P-1:0] p);
    wren[k]          = 1'b1;
    wr_dst[k*A +: A] = d;
    wr_prf[k*P +: P] = p;
  endtask

  task automatic reset_model();
    for (int i = 0; i < N; i++) exp_tbl[i] = P'(i);
  endtask

  // Caller is in the low clock phase; starts a stream and follows it to the end.
  task automatic do_stream(input bit toggle);
    int beat = 0;
    int t = 0;
    int busy_cycles = 0;
    logic [A-1:0]   e_idx;
    logic [L*P-1:0] e_lanes;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    clear_slots();
    while (t < 40) begin
      @(negedge clk);
      clear_slots();
      req = 1'b0;
      rdy = toggle ? (t % 3 == 0) : 1'b1;
      if (toggle && t == 1) set_slot(0, 9, 99);
      if (toggle && t == 2) req = 1'b1;
      #1;
      if (!busy) break;
      busy_cycles++;
      if (beat >= BEATS) begin
        n_checks++; n_fail++;
        $display("FAIL stream_extra_beat: beat %0d still busy, required idle after %0d beats", beat, BEATS);
        break;
      end
      e_idx = A'(beat * L);
      for (int j = 0; j < L; j++) e_lanes[j*P +: P] = exp_tbl[beat*L + j];
      n_checks++;
      if (vld !== 1'b1) begin n_fail++; $display("FAIL stream_vld: got %b required 1 (beat %0d)", vld, beat); end
      n_checks++;
      if (idx !== e_idx) begin n_fail++; $display("FAIL stream_idx: got %0d required %0d", idx, e_idx); end
      n_checks++;
      if (lanes !== e_lanes) begin n_fail++; $display("FAIL stream_lanes: got %h required %h (beat %0d)", lanes, e_lanes, beat); end
      n_checks++;
      if (last !== (beat == BEATS - 1)) begin n_fail++; $display("FAIL stream_last: got %b at beat %0d", last, beat); end
      if (toggle && t == 1) begin
        n_checks++;
        if (ret_vld !== 4'b0000) begin n_fail++; $display("FAIL busy_write_vld: got %b required 0000", ret_vld); end
      end
      if (rdy) beat++;
      t++;
    end
    if (t >= 40) begin
      n_checks++; n_fail++;
      $display("FAIL stream_timeout: still busy after %0d cycles", t);
    end
    n_checks++;
    if (beat != BEATS) begin n_fail++; $display("FAIL stream_beats: got %0d accepted required %0d", beat, BEATS); end
    if (!toggle) begin
      n_checks++;
      if (busy_cycles != BEATS) begin n_fail++; $display("FAIL busy_cycles: got %0d required %0d", busy_cycles, BEATS); end
    end
    n_checks++;
    if (vld !== 1'b0) begin n_fail++; $display("FAIL stream_end_vld: got %b required 0", vld); end
    rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; rdy = 1'b1;
    clear_slots();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++;
    if (vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b required 0", vld); end
    n_checks++;
    if (last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b required 0", last); end
    n_checks++;
    if (idx !== '0) begin n_fail++; $display("FAIL reset_idx: got %0d required 0", idx); end
    n_checks++;
    if (lanes !== '0) begin n_fail++; $display("FAIL reset_lanes: got %h required 0", lanes); end
    n_checks++;
    if (ret_vld !== '0) begin n_fail++; $display("FAIL reset_ret_vld: got %b required 0", ret_vld); end
    @(negedge clk);
    rst = 1'b0;
    reset_model();
  endtask

  task automatic test_full_recovery();
    @(negedge clk);
    do_stream(1'b0);
  endtask

  task automatic test_single_retire();
    @(negedge clk);
    clear_slots();
    set_slot(1, 5, 40);
    #1;
    n_checks++;
    if (ret_vld !== 4'b0010) begin n_fail++; $display("FAIL single_vld: got %b required 0010", ret_vld); end
    n_checks++;
    if (ret_prf[1*P +: P] !== 7'd5) begin n_fail++; $display("FAIL single_prf1: got %0d required 5", ret_prf[1*P +: P]); end
    n_checks++;
    if (ret_prf[0 +: P] !== 7'd0) begin n_fail++; $display("FAIL single_prf0: got %0d required 0", ret_prf[0 +: P]); end
    exp_tbl[5] = 7'd40;
    @(negedge clk);
    clear_slots();
    set_slot(1, 5, 41);
    #1;
    n_checks++;
    if (ret_prf[1*P +: P] !== 7'd40) begin n_fail++; $display("FAIL single_second_prf: got %0d required 40", ret_prf[1*P +: P]); end
    exp_tbl[5] = 7'd41;
    @(negedge clk);
    clear_slots();
  endtask

  task automatic test_collision();
    @(negedge clk);
    clear_slots();
    set_slot(0, 7, 50);
    set_slot(2, 7, 51);
    set_slot(3, 7, 52);
    #1;
    n_checks++;
    if (ret_vld !== 4'b1101) begin n_fail++; $display("FAIL coll_vld: got %b required 1101", ret_vld); end
    n_checks++;
    if (ret_prf !== {7'd51, 7'd50, 7'd0, 7'd7}) begin n_fail++; $display("FAIL coll_prf: got %h required %h", ret_prf, {7'd51, 7'd50, 7'd0, 7'd7}); end
    exp_tbl[7] = 7'd52;
    @(negedge clk);
    clear_slots();
    set_slot(0, 7, 0);
    #1;
    n_checks++;
    if (ret_prf[0 +: P] !== 7'd52) begin n_fail++; $display("FAIL coll_commit: got %0d required 52", ret_prf[0 +: P]); end
    clear_slots();
  endtask

  task automatic test_mixed_bundle();
    @(negedge clk);
    clear_slots();
    set_slot(0, 3, 20);
    set_slot(1, 4, 21);
    set_slot(2, 3, 22);
    wr_dst[3*A +: A] = 5'd4;
    wr_prf[3*P +: P] = 7'd23;
    #1;
    n_checks++;
    if (ret_vld !== 4'b0111) begin n_fail++; $display("FAIL mixed_vld: got %b required 0111", ret_vld); end
    n_checks++;
    if (ret_prf !== {7'd0, 7'd20, 7'd4, 7'd3}) begin n_fail++; $display("FAIL mixed_prf: got %h required %h", ret_prf, {7'd0, 7'd20, 7'd4, 7'd3}); end
    exp_tbl[3] = 7'd22;
    exp_tbl[4] = 7'd21;
    @(negedge clk);
    clear_slots();
  endtask

  task automatic test_dst_zero();
    @(negedge clk);
    clear_slots();
    set_slot(0, 0, 60);
    #1;
    n_checks++;
    if (ret_vld !== 4'b0000) begin n_fail++; $display("FAIL dst0_vld: got %b required 0000", ret_vld); end
    n_checks++;
    if (ret_prf[0 +: P] !== 7'd0) begin n_fail++; $display("FAIL dst0_prf: got %0d required 0", ret_prf[0 +: P]); end
    @(negedge clk);
    clear_slots();
    do_stream(1'b0);
  endtask

  task automatic test_req_with_write();
    @(negedge clk);
    clear_slots();
    set_slot(0, 12, 77);
    #1;
    n_checks++;
    if (ret_prf[0 +: P] !== 7'd12) begin n_fail++; $display("FAIL reqw_prf: got %0d required 12", ret_prf[0 +: P]); end
    exp_tbl[12] = 7'd77;
    do_stream(1'b0);
  endtask

  task automatic test_toggle_recovery();
    @(negedge clk);
    do_stream(1'b1);
    @(negedge clk);
    clear_slots();
    set_slot(0, 9, 0);
    #1;
    n_checks++;
    if (ret_prf[0 +: P] !== exp_tbl[9]) begin n_fail++; $display("FAIL busy_write_table: got %0d required %0d", ret_prf[0 +: P], exp_tbl[9]); end
    clear_slots();
  endtask

  task automatic test_abort();
    bit hit = 1'b0;
    @(negedge clk);
    rdy = 1'b1;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (vld && idx == 5'd16) begin
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b required 0", busy); end
        n_checks++;
        if (vld !== 1'b0) begin n_fail++; $display("FAIL abort_vld: got %b required 0", vld); end
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        hit = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL abort_no_beat2: beat 2 never presented"); end
    @(negedge clk);
    do_stream(1'b0);
  endtask

  initial begin
    test_reset();
    test_full_recovery();
    test_single_retire();
    test_collision();
    test_mixed_bundle();
    test_dst_zero();
    test_req_with_write();
    test_toggle_recovery();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
